// File: rtl/ps_pot_ctrl.sv
// Digital-pot sequencer: SPI power-up (reset, config, initial wiper write), then closed-loop wiper trim.
// Build macro PSPOT_LOCK_EN adds the lock output and the LOCK_CNT parameter.
module ps_pot_ctrl #(
    parameter int ADC_W        = 10,
    parameter int D_W          = 10,
    parameter int THRESH       = 4,
    parameter int STEP         = 1,
    parameter int D_MIN        = 0,
    parameter int D_MAX        = 2**D_W - 1,
    parameter int ADJ_INTERVAL = 1000,
    parameter int INV_POL      = 0
`ifdef PSPOT_LOCK_EN
    ,
    parameter int LOCK_CNT     = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             adj_en,
    input  logic [D_W-1:0]   init_code,
    input  logic [ADC_W-1:0] ps_dig,
    input  logic             dig_valid,
    input  logic [ADC_W-1:0] ps_ref,
    output logic [7:0]       tx_byte,
    output logic             tx_dv,
    input  logic             tx_ready,
    input  logic             cs_n,
    output logic [D_W-1:0]   pot_code,
    output logic [3:0]       state,
    output logic             init_done,
    output logic             busy,
    output logic             sat
`ifdef PSPOT_LOCK_EN
    ,
    output logic             lock
`endif
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RST_HI   = 4'd1,
        S_RST_LO   = 4'd2,
        S_RST_WAIT = 4'd3,
        S_CFG_HI   = 4'd4,
        S_CFG_LO   = 4'd5,
        S_CFG_WAIT = 4'd6,
        S_WR_HI    = 4'd7,
        S_WR_LO    = 4'd8,
        S_WR_WAIT  = 4'd9,
        S_RUN      = 4'd10
    } state_t;

    localparam int CNT_W = (ADJ_INTERVAL > 2) ? $clog2(ADJ_INTERVAL) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(ADJ_INTERVAL - 1);
    localparam logic [D_W:0]        DMIN_X   = (D_W+1)'(D_MIN);
    localparam logic [D_W:0]        DMAX_X   = (D_W+1)'(D_MAX);
    localparam logic [D_W:0]        STEP_X   = (D_W+1)'(STEP);
    localparam logic signed [ADC_W:0] THR_S  = (ADC_W+1)'(THRESH);

    state_t             state_q;
    logic [7:0]         tx_byte_q;
    logic               tx_dv_q;
    logic [D_W-1:0]     pot_code_q;
    logic [D_W-1:0]     pend_q;
    logic               init_done_q;
    logic               busy_q;
    logic               sat_q;
    logic               cs_seen_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               held_q;
    logic [ADC_W-1:0]   dig_held_q;

    logic signed [ADC_W:0] err;
    logic               err_hi;
    logic               err_lo;
    logic               step_up;
    logic               step_dn;
    logic               decide;
    logic [D_W:0]       code_ext;
    logic [D_W:0]       code_sum;
    logic [D_W:0]       code_dif;
    logic [D_W:0]       step_code;
    logic [D_W:0]       init_ext;
    logic [D_W:0]       init_clamp;
    logic [9:0]         wr_data;
    logic [7:0]         hi_byte;
    logic [7:0]         lo_byte;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        err       = $signed({1'b0, dig_held_q}) - $signed({1'b0, ps_ref});
        err_hi    = err > THR_S;
        err_lo    = err < -THR_S;
        step_up   = (INV_POL != 0) ? err_hi : err_lo;
        step_dn   = (INV_POL != 0) ? err_lo : err_hi;
        decide    = (state_q == S_RUN) && (cnt_q == CNT_LAST) && adj_en && held_q;

        code_ext  = {1'b0, pot_code_q};
        code_sum  = code_ext + STEP_X;
        code_dif  = code_ext - STEP_X;
        step_code = code_ext;
        if (step_up) begin
            step_code = (code_sum > DMAX_X) ? DMAX_X : code_sum;
        end else if (step_dn) begin
            // A borrow out of the extended subtraction sets the top bit.
            step_code = (code_dif[D_W] || (code_dif < DMIN_X)) ? DMIN_X : code_dif;
        end

        init_ext   = {1'b0, init_code};
        init_clamp = init_ext;
        if (init_ext < DMIN_X) begin
            init_clamp = DMIN_X;
        end else if (init_ext > DMAX_X) begin
            init_clamp = DMAX_X;
        end
    end

    always_comb begin
        wr_data = 10'(pend_q);
        hi_byte = 8'h00;
        lo_byte = 8'h00;
        case (state_q)
            S_RST_HI, S_RST_LO: begin
                hi_byte = 8'h10;
                lo_byte = 8'h00;
            end
            S_CFG_HI, S_CFG_LO: begin
                hi_byte = 8'h18;
                lo_byte = 8'h02;
            end
            S_WR_HI, S_WR_LO: begin
                hi_byte = {6'b000001, wr_data[9:8]};
                lo_byte = wr_data[7:0];
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tx_byte_q   <= 8'h00;
            tx_dv_q     <= 1'b0;
            pot_code_q  <= DMIN_X[D_W-1:0];
            pend_q      <= DMIN_X[D_W-1:0];
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
            cs_seen_q   <= 1'b0;
            cnt_q       <= '0;
            held_q      <= 1'b0;
            dig_held_q  <= '0;
        end else begin
            tx_dv_q <= 1'b0;

            // A fresh sample always wins over the consumption of the old one.
            if (dig_valid) begin
                dig_held_q <= ps_dig;
                held_q     <= 1'b1;
            end else if (decide) begin
                held_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pend_q  <= init_clamp[D_W-1:0];
                        state_q <= S_RST_HI;
                    end
                end
                S_RST_HI, S_CFG_HI, S_WR_HI: begin
                    if (tx_ready) begin
                        tx_byte_q <= hi_byte;
                        tx_dv_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        cs_seen_q <= 1'b0;
                        state_q   <= state_t'(state_q + 4'd1);
                    end
                end
                S_RST_LO, S_CFG_LO, S_WR_LO: begin
                    if (!cs_n) begin
                        cs_seen_q <= 1'b1;
                    end
                    // The gap on tx_dv_q keeps the two byte pulses at least a cycle apart.
                    if (tx_ready && !tx_dv_q) begin
                        tx_byte_q <= lo_byte;
                        tx_dv_q   <= 1'b1;
                        state_q   <= state_t'(state_q + 4'd1);
                    end
                end
                S_RST_WAIT, S_CFG_WAIT, S_WR_WAIT: begin
                    if (!cs_n) begin
                        cs_seen_q <= 1'b1;
                    end
                    if (cs_seen_q && cs_n && tx_ready) begin
                        busy_q    <= 1'b0;
                        cs_seen_q <= 1'b0;
                        if (state_q == S_RST_WAIT) begin
                            state_q <= S_CFG_HI;
                        end else if (state_q == S_CFG_WAIT) begin
                            state_q <= S_WR_HI;
                        end else begin
                            pot_code_q  <= pend_q;
                            init_done_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (decide) begin
                        if (step_up || step_dn) begin
                            if (step_code != code_ext) begin
                                pend_q  <= step_code[D_W-1:0];
                                sat_q   <= 1'b0;
                                state_q <= S_WR_HI;
                            end else begin
                                sat_q <= 1'b1;
                            end
                        end else begin
                            sat_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PSPOT_LOCK_EN
    localparam int LK_W = $clog2(LOCK_CNT + 1);
    localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(LOCK_CNT - 1);

    logic [LK_W-1:0] lock_cnt_q;
    logic            lock_q;

    // Counts consecutive in-band decisions; any out-of-band decision restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else if (state_q != S_RUN) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else if (decide) begin
            if (step_up || step_dn) begin
                lock_cnt_q <= '0;
                lock_q     <= 1'b0;
            end else if (lock_cnt_q == LOCK_LAST) begin
                lock_q <= 1'b1;
            end else begin
                lock_cnt_q <= lock_cnt_q + LK_W'(1);
            end
        end
    end

    assign lock = lock_q;
`endif

    assign tx_byte   = tx_byte_q;
    assign tx_dv     = tx_dv_q;
    assign pot_code  = pot_code_q;
    assign state     = state_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_ps_pot_ctrl.sv
// Bench for ps_pot_ctrl: two instances (INV_POL 0 and 1) share stimulus, each with its own SPI master model.
module tb_ps_pot_ctrl;

    localparam int ADJ = 40;

    typedef struct {
        logic [9:0] dig;
        logic [9:0] ref_v;
        logic [9:0] code0;
        logic [9:0] code1;
        logic       sat0;
        logic       sat1;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       adj_en = 1'b0;
    logic       dig_valid = 1'b0;
    logic [9:0] init_code = '0;
    logic [9:0] ps_dig = '0;
    logic [9:0] ps_ref = '0;
    logic       hold_rdy = 1'b0;

    logic [1:0][7:0] tx_byte;
    logic [1:0][9:0] pot_code;
    logic [1:0][3:0] state;
    logic [1:0]      tx_dv, tx_ready, cs_n, init_done, busy, sat;
`ifdef PSPOT_LOCK_EN
    logic [1:0]      lock;
`endif

    ps_pot_ctrl #(.ADJ_INTERVAL(ADJ), .INV_POL(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .adj_en(adj_en), .init_code(init_code),
        .ps_dig(ps_dig), .dig_valid(dig_valid), .ps_ref(ps_ref), .tx_byte(tx_byte[0]),
        .tx_dv(tx_dv[0]), .tx_ready(tx_ready[0]), .cs_n(cs_n[0]), .pot_code(pot_code[0]),
        .state(state[0]), .init_done(init_done[0]), .busy(busy[0]), .sat(sat[0])
`ifdef PSPOT_LOCK_EN
        , .lock(lock[0])
`endif
    );

    ps_pot_ctrl #(.ADJ_INTERVAL(ADJ), .INV_POL(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .adj_en(adj_en), .init_code(init_code),
        .ps_dig(ps_dig), .dig_valid(dig_valid), .ps_ref(ps_ref), .tx_byte(tx_byte[1]),
        .tx_dv(tx_dv[1]), .tx_ready(tx_ready[1]), .cs_n(cs_n[1]), .pot_code(pot_code[1]),
        .state(state[1]), .init_done(init_done[1]), .busy(busy[1]), .sat(sat[1])
`ifdef PSPOT_LOCK_EN
        , .lock(lock[1])
`endif
    );

    // SPI master model: takes a byte on tx_dv, drops ready for 2 cycles, frames two bytes per cs_n low.
    logic [1:0] rdy_q = 2'b11;
    logic [1:0] cs_q  = 2'b11;
    logic [1:0] dv_prev = 2'b00;
    int         dly [2];
    int         bc [2];
    int         rx_cnt [2];
    logic [7:0] rx_mem [2][256];
    int         viol = 0;

    assign tx_ready = rdy_q & ~{2{hold_rdy}};
    assign cs_n     = cs_q;

    initial begin
        for (int i = 0; i < 2; i++) begin
            dly[i] = 0;
            bc[i] = 0;
            rx_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rdy_q[i]   <= 1'b1;
                cs_q[i]    <= 1'b1;
                dly[i]     <= 0;
                bc[i]      <= 0;
                dv_prev[i] <= 1'b0;
            end else begin
                if (tx_dv[i] && (!tx_ready[i] || dv_prev[i])) begin
                    viol <= viol + 1;
                end
                dv_prev[i] <= tx_dv[i];
                if (tx_dv[i]) begin
                    if (rx_cnt[i] < 256) begin
                        rx_mem[i][rx_cnt[i]] <= tx_byte[i];
                    end
                    rx_cnt[i] <= rx_cnt[i] + 1;
                    bc[i]     <= bc[i] + 1;
                    rdy_q[i]  <= 1'b0;
                    cs_q[i]   <= 1'b0;
                    dly[i]    <= 2;
                end else if (dly[i] > 0) begin
                    dly[i] <= dly[i] - 1;
                    if (dly[i] == 1) begin
                        rdy_q[i] <= 1'b1;
                        if (bc[i] >= 2) begin
                            cs_q[i] <= 1'b1;
                            bc[i]   <= 0;
                        end
                    end
                end
            end
        end
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_code [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n;
        n = 0;
        while (state[0] != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("reach_state_%0d", s), 32'(state[0]), 32'(s));
    endtask

    task automatic power_up(input logic [9:0] code, input logic [7:0] hi_b, input logic [7:0] lo_b);
        int b0, b1;
        logic [7:0] exp_b [6];
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        b0 = rx_cnt[0];
        b1 = rx_cnt[1];
        init_code = code;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(4'd10, 400);
        exp_b = '{8'h10, 8'h00, 8'h18, 8'h02, hi_b, lo_b};
        check("pu_nbytes0", 32'(rx_cnt[0] - b0), 32'd6);
        check("pu_nbytes1", 32'(rx_cnt[1] - b1), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("pu_byte0_%0d", k), 32'(rx_mem[0][b0 + k]), 32'(exp_b[k]));
            check($sformatf("pu_byte1_%0d", k), 32'(rx_mem[1][b1 + k]), 32'(exp_b[k]));
        end
        check("pu_init_done", 32'(init_done), 32'h3);
        check("pu_pot0", 32'(pot_code[0]), 32'(code));
        check("pu_state1", 32'(state[1]), 32'd10);
        check("pu_busy", 32'(busy), 32'h0);
        exp_code[0] = code;
        exp_code[1] = code;
    endtask

    // One sample, one decision, plus any resulting write frame.
    task automatic apply_vec(input vec_t v, input string tag);
        int b0, b1;
        logic w0, w1;
        b0 = rx_cnt[0];
        b1 = rx_cnt[1];
        w0 = (v.code0 != exp_code[0]);
        w1 = (v.code1 != exp_code[1]);
        ps_dig = v.dig;
        ps_ref = v.ref_v;
        dig_valid = 1'b1;
        @(negedge clk);
        dig_valid = 1'b0;
        repeat (ADJ + 40) @(negedge clk);
        check({tag, "_pot0"}, 32'(pot_code[0]), 32'(v.code0));
        check({tag, "_pot1"}, 32'(pot_code[1]), 32'(v.code1));
        check({tag, "_sat0"}, 32'(sat[0]), 32'(v.sat0));
        check({tag, "_sat1"}, 32'(sat[1]), 32'(v.sat1));
        check({tag, "_state0"}, 32'(state[0]), 32'd10);
        check({tag, "_nbytes0"}, 32'(rx_cnt[0] - b0), w0 ? 32'd2 : 32'd0);
        check({tag, "_nbytes1"}, 32'(rx_cnt[1] - b1), w1 ? 32'd2 : 32'd0);
        if (w0) begin
            check({tag, "_hi0"}, 32'(rx_mem[0][b0]), 32'({6'b000001, v.code0[9:8]}));
            check({tag, "_lo0"}, 32'(rx_mem[0][b0 + 1]), 32'(v.code0[7:0]));
        end
        if (w1) begin
            check({tag, "_hi1"}, 32'(rx_mem[1][b1]), 32'({6'b000001, v.code1[9:8]}));
            check({tag, "_lo1"}, 32'(rx_mem[1][b1 + 1]), 32'(v.code1[7:0]));
        end
        exp_code[0] = v.code0;
        exp_code[1] = v.code1;
    endtask

    vec_t run_tbl [8];
    vec_t clamp_tbl [3];

    initial begin
        int b0, dv_cnt;
        // dig, ref, pot (INV_POL=0), pot (INV_POL=1), sat0, sat1
        run_tbl[0] = '{10'd503,  10'd500,  10'h200, 10'h200, 1'b0, 1'b0};
        run_tbl[1] = '{10'd496,  10'd500,  10'h200, 10'h200, 1'b0, 1'b0};
        run_tbl[2] = '{10'd504,  10'd500,  10'h200, 10'h200, 1'b0, 1'b0};
        run_tbl[3] = '{10'd505,  10'd500,  10'h1FF, 10'h201, 1'b0, 1'b0};
        run_tbl[4] = '{10'd520,  10'd500,  10'h1FE, 10'h202, 1'b0, 1'b0};
        run_tbl[5] = '{10'd495,  10'd500,  10'h1FF, 10'h201, 1'b0, 1'b0};
        run_tbl[6] = '{10'd0,    10'd1023, 10'h200, 10'h200, 1'b0, 1'b0};
        run_tbl[7] = '{10'd1023, 10'd0,    10'h1FF, 10'h201, 1'b0, 1'b0};
        clamp_tbl[0] = '{10'd400, 10'd500, 10'h3FF, 10'h3FE, 1'b1, 1'b0};
        clamp_tbl[1] = '{10'd400, 10'd500, 10'h3FF, 10'h3FD, 1'b1, 1'b0};
        clamp_tbl[2] = '{10'd500, 10'd500, 10'h3FF, 10'h3FD, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'h0);
        check("rst_tx_byte", 32'(tx_byte), 32'h0);
        check("rst_tx_dv", 32'(tx_dv), 32'h0);
        check("rst_pot", 32'(pot_code), 32'h0);
        check("rst_flags", 32'({init_done, busy, sat}), 32'h0);

        // Power-up and closed loop.
        adj_en = 1'b1;
        power_up(10'h200, 8'h06, 8'h00);
        for (int i = 0; i < 5; i++) begin
            apply_vec(run_tbl[0], $sformatf("deadband%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            apply_vec(run_tbl[i], $sformatf("vec%0d", i));
        end

        // start is ignored in RUN.
        b0 = rx_cnt[0];
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("start_in_run_state", 32'(state[0]), 32'd10);
        check("start_in_run_bytes", 32'(rx_cnt[0] - b0), 32'd0);

        // adj_en=0 freezes the loop even with an out-of-band sample held.
        adj_en = 1'b0;
        b0 = rx_cnt[0];
        ps_dig = 10'd700;
        ps_ref = 10'd500;
        dig_valid = 1'b1;
        @(negedge clk);
        dig_valid = 1'b0;
        repeat (3 * ADJ) @(negedge clk);
        check("adj_off_bytes", 32'(rx_cnt[0] - b0), 32'd0);
        check("adj_off_pot0", 32'(pot_code[0]), 32'h1FF);
        check("adj_off_state", 32'(state[0]), 32'd10);

        // Handshake: ready held low in CFG_HI, then reset during WR_LO.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        init_code = 10'h155;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_state(4'd4, 200);
        hold_rdy = 1'b1;
        dv_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_dv != 2'b00) dv_cnt++;
        end
        check("hold_no_dv", 32'(dv_cnt), 32'd0);
        check("hold_state", 32'(state[0]), 32'd4);
        check("hold_busy", 32'(busy[0]), 32'd0);
        hold_rdy = 1'b0;
        wait_state(4'd8, 200);
        check("wr_lo_busy", 32'(busy[0]), 32'd1);
        check("wr_lo_hi_byte", 32'(tx_byte[0]), 32'h05);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_state", 32'(state), 32'h0);
        check("midrst_tx_byte", 32'(tx_byte), 32'h0);
        check("midrst_tx_dv", 32'(tx_dv), 32'h0);
        check("midrst_flags", 32'({init_done, busy, sat}), 32'h0);
        check("midrst_pot", 32'(pot_code), 32'h0);

        // Clamp at D_MAX: INV_POL=0 saturates, INV_POL=1 steps down.
        adj_en = 1'b1;
        power_up(10'h3FF, 8'h07, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            apply_vec(clamp_tbl[i], $sformatf("clamp%0d", i));
        end

`ifdef PSPOT_LOCK_EN
        power_up(10'h200, 8'h06, 8'h00);
        for (int i = 0; i < 7; i++) begin
            apply_vec(run_tbl[0], $sformatf("lock_in%0d", i));
        end
        check("lock_before_8", 32'(lock), 32'h0);
        apply_vec(run_tbl[0], "lock_in7");
        check("lock_after_8", 32'(lock), 32'h3);
        apply_vec(run_tbl[3], "lock_out");
        check("lock_cleared", 32'(lock), 32'h0);
`endif

        check("protocol_violations", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
